// File: rtl/demod_5to8.sv
// Symbol-to-byte repacker: packs SYM_W-bit symbols LSB-first into DATA_W-bit bytes.
// Inverse of the 8-to-5 modulator; one frame is lcm(SYM_W,DATA_W) bits.
module demod_5to8 #(
    parameter int SYM_W   = 5,
    parameter int DATA_W  = 8,
    parameter bit SOF_CHK = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SYM_W-1:0]  sym_in,
    input  logic              sym_vld,
    input  logic              sym_sof,
    output logic              sym_rd,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld,
    input  logic              data_rdy,
    output logic              frame_end,
    output logic              sof_err
);

    function automatic int gcd(input int a, input int b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    localparam int FRAME_SYMS = DATA_W / gcd(SYM_W, DATA_W);
    localparam int PH_W  = (FRAME_SYMS > 1) ? $clog2(FRAME_SYMS) : 1;
    localparam int ACC_W = DATA_W + SYM_W - 1;
    localparam int CNT_W = $clog2(DATA_W + SYM_W);

    localparam logic [PH_W-1:0]  PH_LAST = PH_W'(FRAME_SYMS - 1);
    localparam logic [CNT_W-1:0] SYM_C   = CNT_W'(SYM_W);
    localparam logic [CNT_W-1:0] DATA_C  = CNT_W'(DATA_W);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              vld_q, vld_d;
    logic              fe_q, fe_d;
    logic              sof_err_q, sof_err_d;

    logic              out_free;
    logic              sym_rd_c;
    logic              accept;
    logic              resync;
    logic [ACC_W-1:0]  base_acc;
    logic [CNT_W-1:0]  base_cnt;
    logic [PH_W-1:0]   base_phase;
    logic [ACC_W-1:0]  nacc;
    logic [CNT_W-1:0]  ncnt;
    logic              byte_due;

    // Ready depends only on held state and data_rdy, never on sym_vld.
    always_comb begin
        out_free = !vld_q | data_rdy;
        sym_rd_c = ((cnt_q + SYM_C) < DATA_C) | out_free;
        accept   = sym_vld & sym_rd_c;
        resync   = SOF_CHK & accept & sym_sof & (phase_q != '0);
    end

    // A resync symbol starts from an empty accumulator as phase 0.
    always_comb begin
        base_acc   = resync ? '0 : acc_q;
        base_cnt   = resync ? '0 : cnt_q;
        base_phase = resync ? '0 : phase_q;
        nacc       = base_acc | (ACC_W'(sym_in) << base_cnt);
        ncnt       = base_cnt + SYM_C;
        byte_due   = (ncnt >= DATA_C);
    end

    always_comb begin
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        data_d    = data_q;
        vld_d     = vld_q & !data_rdy;
        fe_d      = fe_q & vld_q & !data_rdy;
        sof_err_d = resync;

        if (accept) begin
            phase_d = (base_phase == PH_LAST) ? '0 : base_phase + 1'b1;
            if (byte_due) begin
                data_d = nacc[DATA_W-1:0];
                vld_d  = 1'b1;
                fe_d   = (base_phase == PH_LAST);
                acc_d  = nacc >> DATA_W;
                cnt_d  = ncnt - DATA_C;
            end else begin
                acc_d = nacc;
                cnt_d = ncnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            phase_q   <= '0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            fe_q      <= 1'b0;
            sof_err_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            fe_q      <= fe_d;
            sof_err_q <= sof_err_d;
        end
    end

    assign sym_rd    = sym_rd_c;
    assign data_out  = data_q;
    assign data_vld  = vld_q;
    assign frame_end = fe_q;
    assign sof_err   = sof_err_q;

endmodule

// File: tb/tb_demod_5to8.sv
// Bench for demod_5to8: known-answer frame table plus a bit-serial
// scoreboard model of the 8-to-5 modulator's inverse.
module tb_demod_5to8;

    typedef struct packed {
        logic [4:0] sym;
        logic       sof;
        logic       has_byte;
        logic [7:0] exp_byte;
        logic       exp_fe;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] sym_in;
    logic       sym_vld;
    logic       sym_sof;
    logic       sym_rd;
    logic [7:0] data_out;
    logic       data_vld;
    logic       data_rdy;
    logic       frame_end;
    logic       sof_err;

    int checks = 0;
    int errors = 0;
    int sof_seen = 0;

    logic [8:0] expq[$];
    logic [7:0] rx_log[$];
    logic       rx_fe[$];
    bit         bitq[$];
    int         msym;
    int         mbyte;
    logic       exp_sof;
    vec_t       tbl[8];
    vec_t       stim[$];

    demod_5to8 dut (
        .clk       (clk),
        .reset     (reset),
        .sym_in    (sym_in),
        .sym_vld   (sym_vld),
        .sym_sof   (sym_sof),
        .sym_rd    (sym_rd),
        .data_out  (data_out),
        .data_vld  (data_vld),
        .data_rdy  (data_rdy),
        .frame_end (frame_end),
        .sof_err   (sof_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        bitq.delete();
        expq.delete();
        msym    = 0;
        mbyte   = 0;
        exp_sof = 1'b0;
    endtask

    // Bit-serial reference: symbols become a bit stream, bytes are cut every 8 bits.
    task automatic model_push(input logic [4:0] s, input logic sof);
        logic [7:0] b;
        logic       fe;
        if (sof && msym != 0) begin
            bitq.delete();
            msym    = 0;
            mbyte   = 0;
            exp_sof = 1'b1;
        end
        for (int i = 0; i < 5; i++) bitq.push_back(s[i]);
        while (bitq.size() >= 8) begin
            for (int i = 0; i < 8; i++) b[i] = bitq.pop_front();
            fe    = (mbyte == 4);
            mbyte = fe ? 0 : mbyte + 1;
            expq.push_back({fe, b});
        end
        msym = (msym == 7) ? 0 : msym + 1;
    endtask

    task automatic step(input logic v, input logic [4:0] s, input logic sof,
                        input logic rdy, output logic took);
        logic [8:0] e;
        sym_vld  = v;
        sym_in   = s;
        sym_sof  = sof;
        data_rdy = rdy;
        #1;
        if (!reset) begin
            chk("sof_err", sof_err, exp_sof);
            if (sof_err) sof_seen++;
        end
        exp_sof = 1'b0;
        if (!reset && data_vld && data_rdy) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_byte: got %0h expected none", data_out);
            end else begin
                e = expq.pop_front();
                chk("data_out", data_out, e[7:0]);
                chk("frame_end", frame_end, e[8]);
            end
            rx_log.push_back(data_out);
            rx_fe.push_back(frame_end);
        end
        took = v && sym_rd && !reset;
        if (took) model_push(s, sof);
        @(negedge clk);
    endtask

    task automatic play(input int vld_pct, input int rdy_pct, output int cyc);
        logic took;
        logic v;
        logic r;
        cyc = 0;
        while (stim.size() > 0 && cyc < 5000) begin
            v = ($urandom_range(99) < vld_pct);
            r = ($urandom_range(99) < rdy_pct);
            step(v, stim[0].sym, stim[0].sof, r, took);
            if (took) void'(stim.pop_front());
            cyc++;
        end
        chk("play_left", stim.size(), 0);
        stim.delete();
    endtask

    task automatic drain();
        logic took;
        int   n;
        n = 0;
        while ((expq.size() > 0 || data_vld) && n < 50) begin
            step(1'b0, 5'h0, 1'b0, 1'b1, took);
            n++;
        end
        step(1'b0, 5'h0, 1'b0, 1'b1, took);
        chk("drained", expq.size(), 0);
    endtask

    task automatic load_tbl(input int first, input int last);
        for (int i = first; i <= last; i++) stim.push_back(tbl[i]);
    endtask

    task automatic check_log(input string tag, input int base);
        int k;
        k = 0;
        chk({tag, "_count"}, rx_log.size() - base, 5);
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].has_byte) begin
                if (base + k < rx_log.size()) begin
                    chk({tag, "_byte"}, rx_log[base+k], tbl[i].exp_byte);
                    chk({tag, "_fe"}, rx_fe[base+k], tbl[i].exp_fe);
                end
                k++;
            end
        end
    endtask

    initial begin
        logic took;
        int   cyc;
        int   base;
        int   fes;
        int   s0;

        tbl[0] = '{5'h12, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{5'h00, 1'b0, 1'b1, 8'h12, 1'b0};
        tbl[2] = '{5'h0D, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{5'h0C, 1'b0, 1'b1, 8'h34, 1'b0};
        tbl[4] = '{5'h05, 1'b0, 1'b1, 8'h56, 1'b0};
        tbl[5] = '{5'h1C, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[6] = '{5'h09, 1'b0, 1'b1, 8'h78, 1'b0};
        tbl[7] = '{5'h13, 1'b0, 1'b1, 8'h9A, 1'b1};

        reset    = 1'b1;
        sym_vld  = 1'b0;
        sym_in   = '0;
        sym_sof  = 1'b0;
        data_rdy = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_data_vld", data_vld, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_frame_end", frame_end, 0);
        chk("rst_sof_err", sof_err, 0);
        chk("rst_sym_rd", sym_rd, 1);
        reset = 1'b0;

        // Single frame, sink always ready
        base = rx_log.size();
        load_tbl(0, 7);
        play(100, 100, cyc);
        chk("t1_cycles", cyc, 8);
        drain();
        check_log("t1", base);

        // Sink stalled: third symbol fits, fourth must wait
        base = rx_log.size();
        step(1'b1, tbl[0].sym, 1'b1, 1'b0, took);
        chk("t2_acc0", took, 1);
        step(1'b1, tbl[1].sym, 1'b0, 1'b0, took);
        chk("t2_acc1", took, 1);
        step(1'b1, tbl[2].sym, 1'b0, 1'b0, took);
        chk("t2_acc2", took, 1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, tbl[3].sym, 1'b0, 1'b0, took);
            if (i == 0 || i == 9) begin
                chk("t2_stall_rd", took, 0);
                chk("t2_hold_vld", data_vld, 1);
                chk("t2_hold_data", data_out, 8'h12);
            end
        end
        load_tbl(3, 7);
        play(100, 100, cyc);
        drain();
        check_log("t2", base);

        // Back-to-back frames at full rate
        base = rx_log.size();
        load_tbl(0, 7);
        load_tbl(0, 7);
        play(100, 100, cyc);
        chk("t3_cycles", cyc, 16);
        drain();
        chk("t3_bytes", rx_log.size() - base, 10);
        fes = 0;
        for (int i = base; i < rx_log.size(); i++) if (rx_fe[i]) fes++;
        chk("t3_frame_ends", fes, 2);

        // Resync: sof on the third symbol
        base = rx_log.size();
        s0 = sof_seen;
        stim.push_back('{5'h1F, 1'b1, 1'b0, 8'h00, 1'b0});
        stim.push_back('{5'h0A, 1'b0, 1'b0, 8'h00, 1'b0});
        load_tbl(0, 7);
        play(100, 100, cyc);
        drain();
        chk("t4_sof_pulses", sof_seen - s0, 1);
        chk("t4_junk_byte", rx_log[base], 8'h5F);
        check_log("t4", base + 1);

        // Reset mid-frame
        load_tbl(0, 3);
        play(100, 100, cyc);
        reset = 1'b1;
        step(1'b0, 5'h0, 1'b0, 1'b0, took);
        step(1'b0, 5'h0, 1'b0, 1'b0, took);
        chk("t5_rst_vld", data_vld, 0);
        chk("t5_rst_data", data_out, 0);
        chk("t5_rst_fe", frame_end, 0);
        chk("t5_rst_sof_err", sof_err, 0);
        reset = 1'b0;
        model_clear();
        base = rx_log.size();
        load_tbl(0, 7);
        play(100, 100, cyc);
        drain();
        check_log("t5", base);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            vec_t v;
            v          = '0;
            v.sym      = 5'($urandom_range(31));
            v.sof      = ($urandom_range(99) < 4);
            stim.push_back(v);
        end
        play(70, 60, cyc);
        drain();

        chk("queue_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
